// File: rtl/sram_block_streamer.sv
// Read-side streamer: fetches N consecutive SRAM entries and emits each entry as
// ELEMENTS_PER_BLOCK elements (LSB element first) over a valid/ready interface.
module sram_block_streamer #(
    parameter int WIDTH              = 128,
    parameter int DEPTH              = 64,
    parameter int LG_DEPTH           = 6,
    parameter int ELEMENTS_PER_BLOCK = 4,
    parameter int ELEMENT_WIDTH      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_req_valid,
    output logic                     io_req_ready,
    input  logic [LG_DEPTH-1:0]      io_req_addr,
    input  logic [LG_DEPTH:0]        io_req_count,
    output logic [LG_DEPTH-1:0]      io_sram_addr,
    output logic                     io_sram_we,
    input  logic [WIDTH-1:0]         io_sram_dout,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [ELEMENT_WIDTH-1:0] io_out_data,
    output logic                     io_out_last,
    output logic                     io_done
);

    localparam int LG_EPB = (ELEMENTS_PER_BLOCK > 1) ? $clog2(ELEMENTS_PER_BLOCK) : 1;
    localparam logic [LG_EPB-1:0] ELEM_MAX = LG_EPB'(ELEMENTS_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STREAM,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [LG_DEPTH-1:0] addr_r;
    logic [LG_DEPTH:0]   remaining;
    logic [WIDTH-1:0]    buffer;
    logic [LG_EPB-1:0]   elem_idx;
    logic                req_fire;
    logic                out_fire;
    logic                block_end;

    assign req_fire  = io_req_valid & io_req_ready;
    assign out_fire  = io_out_valid & io_out_ready;
    assign block_end = (elem_idx == ELEM_MAX);

    // addr_r only moves on the transitions into ISSUE, so it doubles as the held SRAM address
    assign io_sram_addr = addr_r;
    assign io_sram_we   = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_next = (io_req_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE:  state_next = WAIT;
            WAIT:   state_next = STREAM;
            STREAM: begin
                if (out_fire && block_end) begin
                    state_next = (remaining != '0) ? ISSUE : DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        io_req_ready = (state == IDLE) && !reset;
        io_out_valid = (state == STREAM);
        io_done      = (state == DONE);
        io_out_last  = (state == STREAM) && (remaining == '0) && block_end;
        io_out_data  = '0;
        if (state == STREAM) begin
            io_out_data = buffer[int'(elem_idx)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r    <= '0;
            remaining <= '0;
            buffer    <= '0;
            elem_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        addr_r    <= io_req_addr;
                        remaining <= io_req_count;
                    end
                end
                WAIT: begin
                    buffer    <= io_sram_dout;
                    elem_idx  <= '0;
                    remaining <= remaining - (LG_DEPTH+1)'(1);
                end
                STREAM: begin
                    if (out_fire) begin
                        if (!block_end) begin
                            elem_idx <= elem_idx + LG_EPB'(1);
                        end else if (remaining != '0) begin
                            addr_r <= (addr_r == LG_DEPTH'(DEPTH - 1)) ? '0 : addr_r + LG_DEPTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_block_streamer.sv
// Randomised bench for sram_block_streamer with a queue-based reference model of the element stream.
module tb_sram_block_streamer;

    localparam int WIDTH    = 128;
    localparam int DEPTH    = 64;
    localparam int LG_DEPTH = 6;
    localparam int EPB      = 4;
    localparam int EW       = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                io_req_valid;
    logic                io_req_ready;
    logic [LG_DEPTH-1:0] io_req_addr;
    logic [LG_DEPTH:0]   io_req_count;
    logic [LG_DEPTH-1:0] io_sram_addr;
    logic                io_sram_we;
    logic [WIDTH-1:0]    io_sram_dout;
    logic                io_out_valid;
    logic                io_out_ready;
    logic [EW-1:0]       io_out_data;
    logic                io_out_last;
    logic                io_done;

    sram_block_streamer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH),
        .ELEMENTS_PER_BLOCK(EPB), .ELEMENT_WIDTH(EW)
    ) dut (
        .clk(clk), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_addr(io_req_addr), .io_req_count(io_req_count),
        .io_sram_addr(io_sram_addr), .io_sram_we(io_sram_we), .io_sram_dout(io_sram_dout),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_data(io_out_data), .io_out_last(io_out_last), .io_done(io_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data for an address appears one cycle later
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) io_sram_dout <= mem[io_sram_addr];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // reference model state
    logic [EW-1:0]       exp_d [$];
    bit                  exp_l [$];
    logic [LG_DEPTH-1:0] exp_a [$];
    bit                  busy = 0;
    int                  done_at = -100;
    bit                  acc_flag;
    bit                  after_rst = 0;
    bit                  prev_valid = 0, prev_ready = 0, prev_last = 0;
    logic [EW-1:0]       prev_data = '0;
    int                  rmode = 0;
    int                  pat = 0;

    // per-request observations used by the literal checks
    int            accept_cyc, first_valid_cyc, last_cyc, done_cyc, done_cnt, valid_cnt, sram_at1;
    logic [EW-1:0] seen_d [$];
    int            ent_addr [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic model_accept(input int a, input int c);
        logic [WIDTH-1:0] blk;
        int unsigned ea;
        for (int k = 0; k < c; k++) begin
            ea  = (a + k) % DEPTH;
            blk = mem[ea];
            for (int e = 0; e < EPB; e++) begin
                exp_d.push_back(blk[e*EW +: EW]);
                exp_l.push_back((k == c - 1) && (e == EPB - 1));
                exp_a.push_back(ea[LG_DEPTH-1:0]);
            end
        end
    endtask

    // One clock cycle: set ready/noise, compare at the falling edge, advance past the rising edge.
    task automatic tick(input bit nz);
        case (rmode)
            0: io_out_ready = 1'b1;
            1: io_out_ready = 1'($urandom_range(0, 1));
            default: begin io_out_ready = (pat % 3 == 0); pat++; end
        endcase
        if (nz) begin
            if (busy && exp_d.size() > 1) begin
                io_req_valid = 1'($urandom_range(0, 1));
                io_req_addr  = LG_DEPTH'($urandom);
                io_req_count = (LG_DEPTH+1)'($urandom_range(0, DEPTH));
            end else begin
                io_req_valid = 1'b0;
            end
        end
        @(negedge clk);
        if (reset) begin
            check("ready_in_reset", 64'(io_req_ready), 64'(0));
            exp_d.delete(); exp_l.delete(); exp_a.delete();
            busy = 0; done_at = -100; prev_valid = 0; prev_ready = 0; after_rst = 1;
        end else begin
            if (after_rst) begin
                check("rst_sram_addr", 64'(io_sram_addr), 64'(0));
                check("rst_out_data", 64'(io_out_data), 64'(0));
                after_rst = 0;
            end
            if (busy && cyc == done_at + 1) busy = 0;
            check("req_ready", 64'(io_req_ready), 64'(!busy));
            check("done", 64'(io_done), 64'(cyc == done_at));
            check("sram_we", 64'(io_sram_we), 64'(0));
            if (io_done) begin done_cyc = cyc; done_cnt++; end
            if (cyc == accept_cyc + 1) sram_at1 = int'(io_sram_addr);
            if (io_out_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (!prev_valid) ent_addr.push_back(int'(io_sram_addr));
                if (prev_valid && !prev_ready) begin
                    check("stall_data", 64'(io_out_data), 64'(prev_data));
                    check("stall_last", 64'(io_out_last), 64'(prev_last));
                end
                if (exp_d.size() == 0) begin
                    check("unexpected_valid", 64'(io_out_valid), 64'(0));
                end else begin
                    check("out_data", 64'(io_out_data), 64'(exp_d[0]));
                    check("out_last", 64'(io_out_last), 64'(exp_l[0]));
                    check("sram_addr", 64'(io_sram_addr), 64'(exp_a[0]));
                    if (io_out_ready) begin
                        seen_d.push_back(io_out_data);
                        if (exp_l[0]) begin done_at = cyc + 1; last_cyc = cyc; end
                        void'(exp_d.pop_front()); void'(exp_l.pop_front()); void'(exp_a.pop_front());
                    end
                end
            end else begin
                check("last_without_valid", 64'(io_out_last), 64'(0));
            end
            if (io_req_valid && !busy) begin
                busy = 1; acc_flag = 1; accept_cyc = cyc;
                first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
                done_cnt = 0; valid_cnt = 0; sram_at1 = -1;
                seen_d.delete(); ent_addr.delete();
                model_accept(int'(io_req_addr), int'(io_req_count));
                if (io_req_count == '0) done_at = cyc + 1;
            end
            prev_valid = io_out_valid; prev_ready = io_out_ready;
            prev_data  = io_out_data;  prev_last  = io_out_last;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_req(input int a, input int c);
        int n = 0;
        logic [31:0] av, cv;
        av = a; cv = c;
        io_req_valid = 1'b1;
        io_req_addr  = av[LG_DEPTH-1:0];
        io_req_count = cv[LG_DEPTH:0];
        acc_flag = 0;
        while (!acc_flag && n < 50) begin tick(1'b0); n++; end
        io_req_valid = 1'b0;
        check("req_accept_timeout", 64'(acc_flag), 64'(1));
    endtask

    task automatic wait_idle(input bit nz, input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(nz); n++; end
        io_req_valid = 1'b0;
        check("idle_timeout", 64'(busy), 64'(0));
    endtask

    initial begin
        int a, c;
        reset = 1'b1; io_req_valid = 1'b0; io_req_addr = '0; io_req_count = '0; io_out_ready = 1'b1;
        accept_cyc = -10;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        tick(1'b0); tick(1'b0);
        reset = 1'b0;
        tick(1'b0);

        // single entry, full ready: latency and element order
        mem[5] = 128'h44444444_33333333_22222222_11111111;
        rmode = 0;
        do_req(5, 1);
        wait_idle(1'b0, 40);
        check("t1_sram_addr", 64'(sram_at1), 64'(5));
        check("t1_first_valid", 64'(first_valid_cyc - accept_cyc), 64'(3));
        check("t1_last_cycle", 64'(last_cyc - accept_cyc), 64'(6));
        check("t1_done_cycle", 64'(done_cyc - accept_cyc), 64'(7));
        check("t1_count", 64'(seen_d.size()), 64'(4));
        check("t1_e0", 64'(seen_d[0]), 64'(32'h11111111));
        check("t1_e3", 64'(seen_d[3]), 64'(32'h44444444));

        // address wrap 62,63,0,1
        for (int k = 0; k < DEPTH; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
        do_req(62, 4);
        wait_idle(1'b0, 200);
        check("t2_entries", 64'(ent_addr.size()), 64'(4));
        check("t2_addr0", 64'(ent_addr[0]), 64'(62));
        check("t2_addr1", 64'(ent_addr[1]), 64'(63));
        check("t2_addr2", 64'(ent_addr[2]), 64'(0));
        check("t2_addr3", 64'(ent_addr[3]), 64'(1));
        check("t2_elems", 64'(seen_d.size()), 64'(16));
        check("t2_done_pulses", 64'(done_cnt), 64'(1));

        // stalls with ready pattern 1,0,0
        mem[5] = 128'h44444444_33333333_22222222_11111111;
        rmode = 2; pat = 0;
        do_req(5, 1);
        wait_idle(1'b0, 100);
        check("t3_e0", 64'(seen_d[0]), 64'(32'h11111111));
        check("t3_e1", 64'(seen_d[1]), 64'(32'h22222222));
        check("t3_e2", 64'(seen_d[2]), 64'(32'h33333333));
        check("t3_e3", 64'(seen_d[3]), 64'(32'h44444444));

        // zero-count request
        rmode = 0;
        do_req(9, 0);
        wait_idle(1'b0, 20);
        tick(1'b0);
        check("t4_done_cycle", 64'(done_cyc - accept_cyc), 64'(1));
        check("t4_no_valid", 64'(valid_cnt), 64'(0));

        // reset during the second element
        do_req(10, 3);
        for (int n = 0; n < 20 && seen_d.size() < 1; n++) tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        for (int n = 0; n < 8; n++) tick(1'b0);
        check("t5_no_done", 64'(done_cnt), 64'(0));
        do_req(20, 1);
        wait_idle(1'b0, 40);
        check("t5_after_elems", 64'(seen_d.size()), 64'(4));

        // full-depth sweep with request noise
        for (int k = 0; k < DEPTH; k++) mem[k] = {4{32'(k)}};
        do_req(0, 64);
        wait_idle(1'b1, 2000);
        check("t6_elems", 64'(seen_d.size()), 64'(256));
        check("t6_e0", 64'(seen_d[0]), 64'(0));
        check("t6_e150", 64'(seen_d[150]), 64'(37));
        check("t6_e255", 64'(seen_d[255]), 64'(63));

        // randomised requests, ready and noise
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < DEPTH; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
            rmode = int'($urandom_range(0, 1));
            a = int'($urandom_range(0, DEPTH - 1));
            c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 4));
            do_req(a, c);
            wait_idle(1'($urandom_range(0, 1)), 3000);
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
